// File: rtl/me_pkg.sv
// Shared types for the motion-estimation best-MV selection stage.
// Widths, sub-block index, motion vector bundle and selector state.
package me_pkg;

  localparam int SAD_W = 16;
  localparam int COL_W = 5;
  localparam int ROW_W = 7;
  localparam int CNT_W = 12;

  typedef logic [1:0] cb_idx_t;

  typedef struct packed {
    logic [COL_W-1:0] x;
    logic [ROW_W-1:0] y;
  } mv_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_FLUSH,
    S_DRAIN
  } sel_state_t;

endpackage

// File: rtl/sad_min_cell.sv
// One sub-block tracker: running minimum SAD, its MV, hit flag and
// a saturating sample counter. Clear wins over update.
module sad_min_cell
  import me_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             upd_en,
  input  logic [SAD_W-1:0] sad,
  input  mv_t              mv,
  output logic [SAD_W-1:0] min_sad,
  output mv_t              min_mv,
  output logic             hit,
  output logic [CNT_W-1:0] count
);

  logic take;

  // Strict less-than so a tie keeps the earlier candidate.
  assign take = !hit || (sad < min_sad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_sad <= '1;
      min_mv  <= '0;
      hit     <= 1'b0;
      count   <= '0;
    end else if (clr) begin
      min_sad <= '1;
      min_mv  <= '0;
      hit     <= 1'b0;
      count   <= '0;
    end else if (upd_en) begin
      if (take) begin
        min_sad <= sad;
        min_mv  <= mv;
        hit     <= 1'b1;
      end
      if (count != '1) count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/best_mv_selector.sv
// Tracks per-sub-block minimum SAD during a search, then drains
// the four results over a valid/ready handshake.
module best_mv_selector
  import me_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             search_start,
  input  logic             sad_valid,
  input  logic [1:0]       sad_cb_sel,
  input  logic [SAD_W-1:0] sad_value,
  input  logic [COL_W-1:0] sad_col,
  input  logic [ROW_W-1:0] sad_row,
  input  logic             search_done,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_cb_idx,
  output logic [SAD_W-1:0] res_sad,
  output logic [COL_W-1:0] res_mv_x,
  output logic [ROW_W-1:0] res_mv_y,
  output logic             res_hit,
  output logic [CNT_W-1:0] res_count
);

  sel_state_t state, state_nxt;
  cb_idx_t    idx, idx_nxt;
  logic       clr;

  logic             in_valid;
  cb_idx_t          in_sel;
  logic [SAD_W-1:0] in_sad;
  mv_t              in_mv;

  logic [SAD_W-1:0] c_sad [4];
  mv_t              c_mv  [4];
  logic             c_hit [4];
  logic [CNT_W-1:0] c_cnt [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    clr       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (search_start) begin
          clr       = 1'b1;
          state_nxt = S_TRACK;
        end
      end
      S_TRACK: begin
        if (search_start) clr = 1'b1;
        else if (search_done) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        state_nxt = S_DRAIN;
        idx_nxt   = '0;
      end
      S_DRAIN: begin
        if (res_ready) begin
          if (idx == 2'd3) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Samples are only taken while tracking; FLUSH lets the last one land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid <= 1'b0;
      in_sel   <= '0;
      in_sad   <= '0;
      in_mv    <= '0;
    end else begin
      in_valid <= (state == S_TRACK) && sad_valid;
      if ((state == S_TRACK) && sad_valid) begin
        in_sel  <= sad_cb_sel;
        in_sad  <= sad_value;
        in_mv.x <= sad_col;
        in_mv.y <= sad_row;
      end
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_cell
    logic upd;
    assign upd = in_valid && !clr && (in_sel == cb_idx_t'(i));

    sad_min_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .upd_en  (upd),
      .sad     (in_sad),
      .mv      (in_mv),
      .min_sad (c_sad[i]),
      .min_mv  (c_mv[i]),
      .hit     (c_hit[i]),
      .count   (c_cnt[i])
    );
  end

  assign busy       = (state != S_IDLE);
  assign res_valid  = (state == S_DRAIN);
  assign res_cb_idx = idx;
  assign res_sad    = c_sad[idx];
  assign res_mv_x   = c_mv[idx].x;
  assign res_mv_y   = c_mv[idx].y;
  assign res_hit    = c_hit[idx];
  assign res_count  = c_cnt[idx];

endmodule

// File: tb/tb_best_mv_selector.sv
// Directed bench for best_mv_selector with a model-fed scoreboard.
module tb_best_mv_selector;
  import me_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             search_start = 1'b0;
  logic             sad_valid = 1'b0;
  logic [1:0]       sad_cb_sel = '0;
  logic [SAD_W-1:0] sad_value = '0;
  logic [COL_W-1:0] sad_col = '0;
  logic [ROW_W-1:0] sad_row = '0;
  logic             search_done = 1'b0;
  logic             busy;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [1:0]       res_cb_idx;
  logic [SAD_W-1:0] res_sad;
  logic [COL_W-1:0] res_mv_x;
  logic [ROW_W-1:0] res_mv_y;
  logic             res_hit;
  logic [CNT_W-1:0] res_count;

  best_mv_selector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .search_start (search_start),
    .sad_valid    (sad_valid),
    .sad_cb_sel   (sad_cb_sel),
    .sad_value    (sad_value),
    .sad_col      (sad_col),
    .sad_row      (sad_row),
    .search_done  (search_done),
    .busy         (busy),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_cb_idx   (res_cb_idx),
    .res_sad      (res_sad),
    .res_mv_x     (res_mv_x),
    .res_mv_y     (res_mv_y),
    .res_hit      (res_hit),
    .res_count    (res_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cb;
    logic [15:0] sad;
    logic [4:0]  x;
    logic [6:0]  y;
    logic        hit;
    logic [11:0] cnt;
  } res_t;

  res_t q[$];
  res_t got[4];

  int checks = 0;
  int passed = 0;

  logic [15:0] m_min [4];
  logic [4:0]  m_x   [4];
  logic [6:0]  m_y   [4];
  logic        m_hit [4];
  logic [11:0] m_cnt [4];
  logic        m_track = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic m_clear();
    for (int i = 0; i < 4; i++) begin
      m_min[i] = 16'hFFFF;
      m_x[i]   = '0;
      m_y[i]   = '0;
      m_hit[i] = 1'b0;
      m_cnt[i] = '0;
    end
  endtask

  task automatic step(input logic st, input logic v, input logic [1:0] sel,
                      input int sad, input int col, input int row,
                      input logic dn);
    search_start = st;
    sad_valid    = v;
    sad_cb_sel   = sel;
    sad_value    = sad[15:0];
    sad_col      = col[4:0];
    sad_row      = row[6:0];
    search_done  = dn;
    if (st) begin
      m_clear();
      m_track = 1'b1;
    end
    if (v && m_track) begin
      if (!m_hit[sel] || sad[15:0] < m_min[sel]) begin
        m_min[sel] = sad[15:0];
        m_x[sel]   = col[4:0];
        m_y[sel]   = row[6:0];
        m_hit[sel] = 1'b1;
      end
      if (m_cnt[sel] != 12'hFFF) m_cnt[sel] = m_cnt[sel] + 12'd1;
    end
    if (dn && m_track && !st) begin
      m_track = 1'b0;
      for (int i = 0; i < 4; i++)
        q.push_back('{cb: 2'(i), sad: m_min[i], x: m_x[i], y: m_y[i],
                      hit: m_hit[i], cnt: m_cnt[i]});
    end
    @(negedge clk);
    search_start = 1'b0;
    sad_valid    = 1'b0;
    search_done  = 1'b0;
  endtask

  task automatic compare(input string tag, input res_t e);
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_idx"},   32'(res_cb_idx), 32'(e.cb));
    check({tag, "_sad"},   32'(res_sad), 32'(e.sad));
    check({tag, "_x"},     32'(res_mv_x), 32'(e.x));
    check({tag, "_y"},     32'(res_mv_y), 32'(e.y));
    check({tag, "_hit"},   32'(res_hit), 32'(e.hit));
    check({tag, "_cnt"},   32'(res_count), 32'(e.cnt));
  endtask

  task automatic drain(input int stall, input int n_items);
    int   n;
    res_t e;
    n = 0;
    res_ready = 1'b0;
    while (!res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("wait_valid", 32'(res_valid), 32'd1);
    if (q.size() != 0) begin
      for (int s = 0; s < stall; s++) begin
        compare("stall", q[0]);
        @(negedge clk);
      end
    end
    for (int k = 0; k < n_items; k++) begin
      check("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        got[k] = e;
        res_ready = 1'b1;
        compare("item", e);
        got[k].sad = res_sad;
        got[k].x   = res_mv_x;
        got[k].y   = res_mv_y;
        got[k].hit = res_hit;
        got[k].cnt = res_count;
        @(negedge clk);
      end
    end
    res_ready = 1'b0;
  endtask

  initial begin
    m_clear();
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_idx",   32'(res_cb_idx), 32'd0);
    check("rst_sad",   32'(res_sad), 32'hFFFF);
    check("rst_mv",    32'({res_mv_x, res_mv_y}), 32'd0);
    check("rst_hit",   32'(res_hit), 32'd0);
    check("rst_cnt",   32'(res_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic min, tie, same-cycle done; plus a sample ignored in IDLE
    step(0, 1, 2'd0, 5, 0, 0, 0);
    step(1, 0, 2'd0, 0, 0, 0, 0);
    check("track_busy", 32'(busy), 32'd1);
    step(0, 1, 2'd0, 500, 1, 0, 0);
    step(0, 1, 2'd0, 300, 1, 5, 0);
    step(0, 1, 2'd0, 400, 2, 3, 0);
    step(0, 1, 2'd2, 200, 3, 4, 0);
    step(0, 1, 2'd2, 200, 4, 0, 0);
    step(0, 1, 2'd3, 10, 7, 9, 1);
    drain(0, 4);
    check("idle_valid", 32'(res_valid), 32'd0);
    check("idle_busy",  32'(busy), 32'd0);
    check("basic_sad",  32'(got[0].sad), 32'd300);
    check("basic_mv",   32'({got[0].x, got[0].y}), 32'({5'd1, 7'd5}));
    check("basic_cnt",  32'(got[0].cnt), 32'd3);
    check("tie_sad",    32'(got[2].sad), 32'd200);
    check("tie_mv",     32'({got[2].x, got[2].y}), 32'({5'd3, 7'd4}));
    check("tie_cnt",    32'(got[2].cnt), 32'd2);
    check("same_sad",   32'(got[3].sad), 32'd10);
    check("same_mv",    32'({got[3].x, got[3].y}), 32'({5'd7, 7'd9}));

    // only CB1 fed, backpressure on the first result
    step(1, 0, 2'd0, 0, 0, 0, 0);
    step(0, 1, 2'd1, 77, 3, 3, 0);
    step(0, 1, 2'd1, 66, 2, 8, 0);
    step(0, 0, 2'd0, 0, 0, 0, 1);
    drain(5, 4);
    check("nohit0",     32'({got[0].hit, got[0].sad}), 32'({1'b0, 16'hFFFF}));
    check("hit1",       32'({got[1].hit, got[1].sad}), 32'({1'b1, 16'd66}));
    check("nohit3",     32'(got[3].hit), 32'd0);
    check("bp_busy",    32'(busy), 32'd0);
    check("bp_valid",   32'(res_valid), 32'd0);

    // restart discards the in-flight sample
    step(1, 0, 2'd0, 0, 0, 0, 0);
    step(0, 1, 2'd0, 60, 1, 1, 0);
    step(0, 1, 2'd0, 50, 2, 2, 0);
    step(1, 1, 2'd0, 900, 0, 1, 0);
    step(0, 0, 2'd0, 0, 0, 0, 1);
    drain(0, 4);
    check("rs_sad", 32'(got[0].sad), 32'd900);
    check("rs_cnt", 32'(got[0].cnt), 32'd1);

    // saturation, then reset during drain
    step(1, 0, 2'd0, 0, 0, 0, 0);
    for (int i = 0; i < 4100; i++)
      step(0, 1, 2'd1, 1000 + (i % 97), i % 32, i % 128, i == 4099);
    drain(0, 2);
    check("sat_cnt", 32'(got[1].cnt), 32'd4095);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_sad",  32'(res_sad), 32'hFFFF);
    check("arst_cnt",  32'(res_count), 32'd0);
    check("arst_idx",  32'(res_cb_idx), 32'd0);
    q.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_valid", 32'(res_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/best_mv_selector.md
Name: best_mv_selector

Overview:
- Sits directly downstream of the PE array and its controller in the DMT motion-estimation pipeline.
- Consumes per-candidate SAD results tagged with the sub-block select (abs_Control encoding), search column count and search row count.
- Keeps the running minimum SAD and its motion vector for each of the four coding sub-blocks (CB1..CB4).
- At end of search, drains the four results one at a time over a valid/ready interface to the mode-decision stage.

Parameters:
SAD_W, 16, SAD value width
COL_W, 5, search column count width (MV x)
ROW_W, 7, search row count width (MV y)
CNT_W, 12, per-CB evaluated-candidate counter width (saturating)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
search_start  in  1  single-cycle pulse; clears all trackers and starts a search
sad_valid  in  1  SAD sample present this cycle
sad_cb_sel  in  2  sub-block index 0..3 (same encoding as abs_Control)
sad_value  in  SAD_W  candidate SAD
sad_col  in  COL_W  search column count of the candidate
sad_row  in  ROW_W  search row count of the candidate
search_done  in  1  single-cycle pulse; last sample is on or before this cycle
busy  out  1  high in every state except IDLE
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
res_cb_idx  out  2  sub-block of the presented result
res_sad  out  SAD_W  minimum SAD
res_mv_x  out  COL_W  column of the minimum
res_mv_y  out  ROW_W  row of the minimum
res_hit  out  1  at least one sample was received for this CB
res_count  out  CNT_W  samples received for this CB, saturating at all-ones

Behaviour:
- Reset: state IDLE; busy=0, res_valid=0, res_cb_idx=0, res_sad=all-ones, res_mv_x=0, res_mv_y=0, res_hit=0, res_count=0; all trackers hold min=all-ones, mv=0, hit=0, count=0.
- FSM states: IDLE, TRACK, FLUSH, DRAIN.
- IDLE:
  - search_start -> clear all trackers, go to TRACK.
  - sad_valid and search_done are ignored.
- Input stage: when in TRACK, a sample is captured into an input register (1 cycle). The comparison and tracker update happen on the following cycle. Total latency from sample to tracker update is 2 edges.
- Compare rule, per tracker:
  - Update when hit==0 or sad < min (strict less-than); a tie keeps the earlier candidate.
  - On update, load min, mv_x and mv_y from the sample and set hit=1.
  - count increments on every sample for that CB and saturates at 2^CNT_W-1.
- TRACK:
  - search_done -> FLUSH. A sad_valid asserted in the same cycle as search_done is included.
  - search_start in TRACK restarts the search: trackers are cleared, the registered in-flight sample is discarded, and a sad_valid in the same cycle is captured as the first sample of the new search.
- FLUSH: one cycle while the input register commits its last sample; then -> DRAIN with res_cb_idx=0.
- DRAIN:
  - res_valid=1; outputs reflect tracker[res_cb_idx].
  - res_valid and all res_* outputs stay stable while res_ready=0.
  - On res_valid&&res_ready: idx<3 -> idx+1; idx==3 -> res_valid=0 and go to IDLE in the same edge.
  - search_start, sad_valid and search_done are ignored in DRAIN and FLUSH.
- A CB with no samples drains with res_hit=0, res_sad=all-ones, mv=0, count=0.
- res_ready held high: the four results drain in 4 consecutive cycles.
- Reset asserted mid-operation returns immediately to the reset values above; no partial result is emitted.

Decomposition:
- Shared package me_pkg holds: SAD_W/COL_W/ROW_W/CNT_W constants, the cb_idx_t 2-bit typedef, the mv_t struct {x, y}, and the selector state enum.
- One natural sub-module, sad_min_cell: one tracker register set plus comparator, instantiated 4 times, with ports clr, upd_en, sad, mv, and outputs min/mv/hit/count.

Test Plan:
- Basic min: start; CB0 samples (SAD 500,col 1,row 0), (300,1,5), (400,2,3); done -> first result idx0, sad=300, mv=(1,5), hit=1, count=3.
- Tie: CB2 samples (200,3,4) then (200,4,0) -> idx2 sad=200, mv=(3,4), count=2.
- No-hit/backpressure: only CB1 fed; res_ready low 5 cycles in DRAIN -> idx0 held stable with hit=0, sad=0xFFFF; then CB1 hit=1, then CB2 and CB3 hit=0; IDLE after 4th handshake, busy=0.
- Same-cycle done: sample (10,7,9) on CB3 together with search_done -> idx3 sad=10, mv=(7,9).
- Restart: TRACK with CB0 min=50, then search_start with sample (900,0,1) on CB0, then done -> idx0 sad=900, count=1.
- Saturation and reset: 4100 CB1 samples -> count=4095; assert rst_n low during DRAIN -> res_valid=0 next cycle, state IDLE.
